// File: rtl/dm_access_arbiter_pkg.sv
// Shared constants for the data-memory access arbiter: op codes, memory size and FSM encoding.
// Imported by the arbiter top and its address/op fault checker.
package dm_access_arbiter_pkg;

   localparam int DM_WORDS_DFLT = 3072;
   localparam int ADDR_W_DFLT   = 32;

   localparam logic [2:0] OP_WORD = 3'd0;
   localparam logic [2:0] OP_HALF = 3'd1;
   localparam logic [2:0] OP_BYTE = 3'd2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dm_access_check.sv
// Combinational access checker: flags illegal op codes, misaligned word/half accesses
// and byte addresses beyond the end of the data memory.
module dm_access_check
   import dm_access_arbiter_pkg::*;
#(
   parameter int DM_WORDS = DM_WORDS_DFLT,
   parameter int ADDR_W   = ADDR_W_DFLT
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [2:0]        i_op,
   output logic              o_fault
);

   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DM_WORDS * 4);

   logic w_align_fault;
   logic w_range_fault;

   always_comb begin
      w_align_fault = 1'b0;
      case (i_op)
         OP_WORD: w_align_fault = (i_addr[1:0] != 2'b00);
         OP_HALF: w_align_fault = i_addr[0];
         OP_BYTE: w_align_fault = 1'b0;
         default: w_align_fault = 1'b1;
      endcase
   end

   assign w_range_fault = (i_addr >= LIMIT);
   assign o_fault       = w_align_fault | w_range_fault;

endmodule

// File: rtl/dm_access_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the data memory.
// Each access takes one SERVE cycle; completion is a one-cycle ack with registered data.
module dm_access_arbiter
   import dm_access_arbiter_pkg::*;
#(
   parameter int DM_WORDS = DM_WORDS_DFLT,
   parameter int ADDR_W   = ADDR_W_DFLT
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [2:0]        p0_op,
   input  logic [31:0]       p0_wdata,
   input  logic [31:0]       p0_pc,
   output logic              p0_ack,
   output logic [31:0]       p0_rdata,
   output logic              p0_err,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [2:0]        p1_op,
   input  logic [31:0]       p1_wdata,
   input  logic [31:0]       p1_pc,
   output logic              p1_ack,
   output logic [31:0]       p1_rdata,
   output logic              p1_err,

   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [2:0]        dm_op,
   output logic [31:0]       dm_din,
   output logic [31:0]       dm_pc,
   input  logic [31:0]       dm_dout,

   output logic              busy
);

   state_t              r_state;
   state_t              w_next_state;
   logic                r_prio;

   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [2:0]          r_op;
   logic [31:0]         r_wdata;
   logic [31:0]         r_pc;
   logic                r_port;
   logic                r_err;

   logic                r_p0_ack;
   logic [31:0]         r_p0_rdata;
   logic                r_p0_err;
   logic                r_p1_ack;
   logic [31:0]         r_p1_rdata;
   logic                r_p1_err;

   logic                w_elig0;
   logic                w_elig1;
   logic                w_grant;
   logic                w_gport;
   logic                w_mux_we;
   logic [ADDR_W-1:0]   w_mux_addr;
   logic [2:0]          w_mux_op;
   logic [31:0]         w_mux_wdata;
   logic [31:0]         w_mux_pc;
   logic                w_fault;
   logic                w_latch;
   logic                w_serve;
   logic [31:0]         w_resp_rdata;

   // A port whose ack is showing this cycle is masked so its held req is not re-served.
   assign w_elig0 = p0_req && !r_p0_ack;
   assign w_elig1 = p1_req && !r_p1_ack;
   assign w_grant = w_elig0 || w_elig1;

   always_comb begin
      w_gport = PORT0;
      if (w_elig0 && w_elig1) begin
         w_gport = r_prio;
      end else if (w_elig1) begin
         w_gport = PORT1;
      end
   end

   assign w_mux_we    = w_gport ? p1_we    : p0_we;
   assign w_mux_addr  = w_gport ? p1_addr  : p0_addr;
   assign w_mux_op    = w_gport ? p1_op    : p0_op;
   assign w_mux_wdata = w_gport ? p1_wdata : p0_wdata;
   assign w_mux_pc    = w_gport ? p1_pc    : p0_pc;

   dm_access_check #(
      .DM_WORDS (DM_WORDS),
      .ADDR_W   (ADDR_W)
   ) u_check (
      .i_addr  (w_mux_addr),
      .i_op    (w_mux_op),
      .o_fault (w_fault)
   );

   assign w_latch = (r_state == ST_IDLE) && w_grant;
   assign w_serve = (r_state == ST_SERVE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_grant) w_next_state = ST_SERVE;
         ST_SERVE: w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Memory side is only driven from the request register while serving.
   // Reset gates the write enable so an access caught by reset never commits.
   always_comb begin
      dm_we   = 1'b0;
      dm_addr = '0;
      dm_op   = OP_WORD;
      dm_din  = '0;
      dm_pc   = '0;
      busy    = 1'b0;
      if (r_state == ST_SERVE) begin
         dm_we   = r_we && !r_err && !reset;
         dm_addr = r_addr;
         dm_op   = r_op;
         dm_din  = r_wdata;
         dm_pc   = r_pc;
         busy    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prio  <= PORT0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_op    <= OP_WORD;
         r_wdata <= '0;
         r_pc    <= '0;
         r_port  <= PORT0;
         r_err   <= 1'b0;
      end else if (w_latch) begin
         r_prio  <= ~w_gport;
         r_we    <= w_mux_we;
         r_addr  <= w_mux_addr;
         r_op    <= w_mux_op;
         r_wdata <= w_mux_wdata;
         r_pc    <= w_mux_pc;
         r_port  <= w_gport;
         r_err   <= w_fault;
      end
   end

   assign w_resp_rdata = (r_we || r_err) ? 32'd0 : dm_dout;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_p0_ack   <= 1'b0;
         r_p0_rdata <= '0;
         r_p0_err   <= 1'b0;
         r_p1_ack   <= 1'b0;
         r_p1_rdata <= '0;
         r_p1_err   <= 1'b0;
      end else begin
         r_p0_ack <= w_serve && (r_port == PORT0);
         r_p1_ack <= w_serve && (r_port == PORT1);
         if (w_serve && (r_port == PORT0)) begin
            r_p0_rdata <= w_resp_rdata;
            r_p0_err   <= r_err;
         end
         if (w_serve && (r_port == PORT1)) begin
            r_p1_rdata <= w_resp_rdata;
            r_p1_err   <= r_err;
         end
      end
   end

   assign p0_ack   = r_p0_ack;
   assign p0_rdata = r_p0_rdata;
   assign p0_err   = r_p0_err;
   assign p1_ack   = r_p1_ack;
   assign p1_rdata = r_p1_rdata;
   assign p1_err   = r_p1_err;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed bench for dm_access_arbiter: expected responses are queued when a request is
// driven and compared in order whenever either port acks.
module tb_dm_access_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p0_pc, p1_addr, p1_wdata, p1_pc;
   logic [2:0]  p0_op, p1_op;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        dm_we;
   logic [31:0] dm_addr, dm_din, dm_pc, dm_dout;
   logic [2:0]  dm_op;
   logic        busy;

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   dm_access_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .p0_req   (p0_req),
      .p0_we    (p0_we),
      .p0_addr  (p0_addr),
      .p0_op    (p0_op),
      .p0_wdata (p0_wdata),
      .p0_pc    (p0_pc),
      .p0_ack   (p0_ack),
      .p0_rdata (p0_rdata),
      .p0_err   (p0_err),
      .p1_req   (p1_req),
      .p1_we    (p1_we),
      .p1_addr  (p1_addr),
      .p1_op    (p1_op),
      .p1_wdata (p1_wdata),
      .p1_pc    (p1_pc),
      .p1_ack   (p1_ack),
      .p1_rdata (p1_rdata),
      .p1_err   (p1_err),
      .dm_we    (dm_we),
      .dm_addr  (dm_addr),
      .dm_op    (dm_op),
      .dm_din   (dm_din),
      .dm_pc    (dm_pc),
      .dm_dout  (dm_dout),
      .busy     (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic port, input logic req, input logic we,
                        input logic [31:0] addr, input logic [2:0] op, input logic [31:0] wdata);
      if (port == 1'b0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_op = op; p0_wdata = wdata;
         p0_pc = 32'h0000_1000 + addr;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_op = op; p1_wdata = wdata;
         p1_pc = 32'h0000_2000 + addr;
      end
   endtask

   task automatic push_exp(input logic port, input logic [31:0] rdata, input logic err);
      exp_t e;
      e.port  = port;
      e.rdata = rdata;
      e.err   = err;
      q.push_back(e);
   endtask

   // Single isolated access starting from IDLE with no ack pending.
   task automatic do_access(input string tag, input logic port, input logic we,
                            input logic [31:0] addr, input logic [2:0] op,
                            input logic [31:0] wdata, input logic [31:0] dout, input logic err);
      logic [31:0] pc;
      pc      = (port ? 32'h0000_2000 : 32'h0000_1000) + addr;
      dm_dout = dout;
      push_exp(port, (we || err) ? 32'd0 : dout, err);
      drive(port, 1'b1, we, addr, op, wdata);
      tick();
      check({tag, "_busy"},  32'(busy), 32'd1);
      check({tag, "_dm_we"}, 32'(dm_we), 32'(we && !err));
      check({tag, "_addr"},  dm_addr, addr);
      check({tag, "_op"},    32'(dm_op), 32'(op));
      check({tag, "_din"},   dm_din, wdata);
      check({tag, "_pc"},    dm_pc, pc);
      tick();
      check({tag, "_ack"},   32'(port ? p1_ack : p0_ack), 32'd1);
      check({tag, "_we_off"}, 32'(dm_we), 32'd0);
      drive(port, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      tick();
   endtask

   // Scoreboard: every ack must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (p0_ack || p1_ack) begin
         check("sb_ack_expected", 32'(q.size() != 0), 32'd1);
         check("sb_single_ack", 32'(p0_ack && p1_ack), 32'd0);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("sb_port", 32'(p1_ack), 32'(e.port));
            check("sb_rdata", p1_ack ? p1_rdata : p0_rdata, e.rdata);
            check("sb_err", 32'(p1_ack ? p1_err : p0_err), 32'(e.err));
         end
      end
   end

   initial begin
      reset   = 1'b1;
      dm_dout = 32'd0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      repeat (2) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dm_we", 32'(dm_we), 32'd0);
      check("rst_acks", {30'd0, p1_ack, p0_ack}, 32'd0);
      check("rst_errs", {30'd0, p1_err, p0_err}, 32'd0);
      check("rst_p0_rdata", p0_rdata, 32'd0);
      check("rst_p1_rdata", p1_rdata, 32'd0);
      check("rst_dm_addr", dm_addr, 32'd0);
      reset = 1'b0;
      tick();

      // Basic read and write
      do_access("t1_rd", 1'b0, 1'b0, 32'h10, 3'd0, 32'd0, 32'hDEAD_BEEF, 1'b0);
      do_access("t2_wr", 1'b1, 1'b1, 32'h22, 3'd1, 32'h1234, 32'h5555_AAAA, 1'b0);

      // Continuous contention: grants alternate starting from port 0
      dm_dout = 32'hCAFE_0001;
      for (int i = 0; i < 6; i++) push_exp(i[0], 32'hCAFE_0001, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h40, 3'd0, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h80, 3'd0, 32'd0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         check("t3_ack_spacing", 32'(p0_ack || p1_ack), 32'((k % 2) == 0));
         if ((k % 2) == 1) check("t3_grant_addr", dm_addr, ((k / 2) % 2) ? 32'h80 : 32'h40);
      end
      drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      tick();

      // Faults and the last legal byte
      do_access("t4_word_mis", 1'b0, 1'b0, 32'h13, 3'd0, 32'd0, 32'h1111_1111, 1'b1);
      do_access("t4_half_mis", 1'b0, 1'b1, 32'h21, 3'd1, 32'h77, 32'h2222_2222, 1'b1);
      do_access("t4_range", 1'b1, 1'b1, 32'h3000, 3'd2, 32'h5A, 32'h3333_3333, 1'b1);
      do_access("t4_bad_op", 1'b1, 1'b1, 32'h4, 3'd5, 32'h99, 32'h4444_4444, 1'b1);
      do_access("t4_last_byte", 1'b1, 1'b0, 32'h2FFF, 3'd2, 32'd0, 32'hFFFF_FF80, 1'b0);

      // Reset during the SERVE cycle of a write
      drive(1'b0, 1'b1, 1'b1, 32'h100, 3'd0, 32'hABCD_0123);
      tick();
      check("t5_serve_we", 32'(dm_we), 32'd1);
      reset = 1'b1;
      #1;
      check("t5_we_suppressed", 32'(dm_we), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      tick();
      check("t5_no_ack", {30'd0, p1_ack, p0_ack}, 32'd0);
      check("t5_busy", 32'(busy), 32'd0);
      check("t5_dm_we", 32'(dm_we), 32'd0);
      check("t5_p0_err_clr", 32'(p0_err), 32'd0);
      check("t5_p1_rdata_clr", p1_rdata, 32'd0);
      reset = 1'b0;
      tick();
      check("t5_no_ack_late", {30'd0, p1_ack, p0_ack}, 32'd0);
      dm_dout = 32'h0BAD_F00D;
      push_exp(1'b0, 32'h0BAD_F00D, 1'b0);
      push_exp(1'b1, 32'h0BAD_F00D, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h200, 3'd0, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h300, 3'd0, 32'd0);
      tick();
      check("t5_first_grant", dm_addr, 32'h200);
      tick();
      tick();
      check("t5_second_grant", dm_addr, 32'h300);
      tick();
      drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      tick();

      // Port 0 holds req through its ack: re-granted 3 cycles after the first grant
      dm_dout = 32'h0000_0042;
      push_exp(1'b0, 32'h0000_0042, 1'b0);
      push_exp(1'b0, 32'h0000_0042, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h44, 3'd0, 32'd0);
      tick();
      check("t6_grant1", 32'(busy), 32'd1);
      tick();
      check("t6_ack1", 32'(p0_ack), 32'd1);
      check("t6_ack1_idle", 32'(busy), 32'd0);
      tick();
      check("t6_gap_idle", 32'(busy), 32'd0);
      check("t6_gap_ack", 32'(p0_ack), 32'd0);
      tick();
      check("t6_grant2", 32'(busy), 32'd1);
      tick();
      check("t6_ack2", 32'(p0_ack), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 3'd0, 32'd0);
      tick();
      tick();
      check("t6_quiet", 32'(busy), 32'd0);

      check("sb_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
